hazard_match_pipe: RTL and testbench
====================================

// Module: hazard_match_pipe
// PURPOSE
//  Register-address/control pipeline D->E->M->W feeding the hazard unit. Carries source/dest
//  register numbers and RegWrite/MemtoReg down the pipe, applies FlushE (load-use bubble),
//  and produces the Match_* compare signals the hazard unit consumes. Also counts bubbles.
// PARAMETERS
//  ADDR_W   4    register-number width
//  PC_REG   15   register number never reported as a match (PC reads are not forwarded)
//  CNT_W    16   width of saturating bubble counter
// PORTS
//  clk           in   1        rising-edge clock
//  reset_n       in   1        asynchronous active-low reset
//  RA1D          in   ADDR_W   source reg 1, decode stage
//  RA2D          in   ADDR_W   source reg 2, decode stage
//  WA3D          in   ADDR_W   dest reg, decode stage
//  ValidD        in   1        decode holds a real instruction
//  RegWriteD     in   1        decode instruction writes WA3D
//  MemtoRegD     in   1        decode instruction is a load
//  FlushE        in   1        from hazard unit: load E-stage with a bubble
//  RA1E,RA2E     out  ADDR_W   registered sources, execute stage
//  WA3E,WA3M,WA3W out ADDR_W   registered dest per stage
//  RegWriteM     out  1        RegWrite of M stage (valid-gated)
//  RegWriteW     out  1        RegWrite of W stage (valid-gated)
//  MemtoRegE     out  1        E-stage instruction is a load (valid-gated)
//  Match_1E_M    out  1        RA1E==WA3M
//  Match_1E_W    out  1        RA1E==WA3W
//  Match_2E_M    out  1        RA2E==WA3M
//  Match_2E_W    out  1        RA2E==WA3W
//  Match_12D_E   out  1        RA1D==WA3E or RA2D==WA3E
//  BubbleCount   out  CNT_W    number of bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): all stage regs, valid bits, control bits, BubbleCount = 0;
//    therefore every Match_* = 0, RegWriteM/W = 0, MemtoRegE = 0. Outputs hold 0 while low.
//  - Each posedge: W<=M, M<=E unconditionally (M and W never stall or flush).
//  - E stage: if FlushE, ValidE<=0, RegWriteE<=0, MemtoRegE<=0 (address fields may hold any
//    value, contents don't-care); else E<=D fields with ValidE<=ValidD.
//  - FlushE and new D data in same cycle: flush wins for E; M still captures old E.
//  - Control outputs are valid-gated: RegWriteX_out = RegWriteX & ValidX.
//  - Match_nE_X = ValidE & ValidX & RegWriteX & (RAnE==WA3X) & (RAnE!=PC_REG); combinational
//    from registered state, zero-cycle latency.
//  - Match_12D_E = ValidD & ValidE & RegWriteE & ((RA1D==WA3E & RA1D!=PC_REG) |
//    (RA2D==WA3E & RA2D!=PC_REG)); combinational from D inputs and E state.
//  - Matching RegWrite-gating here is in addition to the hazard unit's gating (harmless).
//  - Latency: D fields reach E outputs 1 cycle later, M 2, W 3.
//  - BubbleCount: +1 on each posedge where FlushE=1; saturates at all-ones (no wrap).
//  - Reset asserted mid-operation: in-flight instructions discarded, no matches afterward
//    until new valid instructions reach the compared stages.
// TESTING
//  1 Reset: hold reset_n=0 4 cycles with random D inputs -> all outputs 0, BubbleCount=0.
//  2 Back-to-back dependency: I0 WA3D=3 RegWrite=1, then I1 RA1D=3 -> next cycle Match_1E_M=1;
//    following cycle Match_1E_W=1, Match_1E_M=0.
//  3 Load-use: I0 load WA3D=5 in E (MemtoRegE=1), RA2D=5 in D -> Match_12D_E=1; FlushE=1 one
//    cycle -> ValidE=0, MemtoRegE=0, Match_12D_E=0, BubbleCount=1.
//  4 PC exclusion: WA3D=15 RegWrite=1 then RA1D=15 -> all Match_* stay 0.
//  5 RegWrite=0 or ValidD=0 producer with equal addresses -> no match in any stage.
//  6 Saturation: CNT_W=4, FlushE=1 for 20 cycles -> BubbleCount=15, holds; reset -> 0.

Source files
------------

// File: rtl/hazard_match_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_match_pipe
//  Purpose  : Register-address / control pipeline D->E->M->W for the hazard
//             unit. Carries source and destination register numbers plus
//             RegWrite/MemtoReg down the pipe. FlushE turns the E stage into
//             a bubble. The module produces the Match_* compare signals and
//             keeps a saturating count of the bubbles it has inserted.
//  Ports    : clk, reset_n (async, active low)
//             RA1D/RA2D/WA3D, ValidD, RegWriteD, MemtoRegD  - decode stage in
//             FlushE                                        - bubble request
//             RA1E/RA2E/WA3E/WA3M/WA3W                      - stage addresses
//             RegWriteM/RegWriteW/MemtoRegE                 - valid-gated ctrl
//             Match_1E_M/1E_W/2E_M/2E_W/12D_E               - compare results
//             BubbleCount                                   - bubbles since reset
//  Revision : 1.0  initial release
// ============================================================================
module hazard_match_pipe #(
  parameter int ADDR_W = 4,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WA3D,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              FlushE,
  output logic [ADDR_W-1:0] RA1E,
  output logic [ADDR_W-1:0] RA2E,
  output logic [ADDR_W-1:0] WA3E,
  output logic [ADDR_W-1:0] WA3M,
  output logic [ADDR_W-1:0] WA3W,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegE,
  output logic              Match_1E_M,
  output logic              Match_1E_W,
  output logic              Match_2E_M,
  output logic              Match_2E_W,
  output logic              Match_12D_E,
  output logic [CNT_W-1:0]  BubbleCount
);

  // PC reads are never forwarded, so the PC register number never matches.
  localparam logic [ADDR_W-1:0] c_pc_reg = ADDR_W'(PC_REG);

  // ---------------- stage registers ----------------
  logic [ADDR_W-1:0] ra1_e_q, ra1_e_d;
  logic [ADDR_W-1:0] ra2_e_q, ra2_e_d;
  logic [ADDR_W-1:0] wa3_e_q, wa3_e_d;
  logic              valid_e_q, valid_e_d;
  logic              regwrite_e_q, regwrite_e_d;
  logic              memtoreg_e_q, memtoreg_e_d;

  logic [ADDR_W-1:0] wa3_m_q, wa3_m_d;
  logic              valid_m_q, valid_m_d;
  logic              regwrite_m_q, regwrite_m_d;

  logic [ADDR_W-1:0] wa3_w_q, wa3_w_d;
  logic              valid_w_q, valid_w_d;
  logic              regwrite_w_q, regwrite_w_d;

  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  // ---------------- next-state logic ----------------
  always_comb begin
    // Address fields follow D even on a flush; they are don't-care once the
    // stage is marked invalid, and this avoids an extra mux.
    ra1_e_d      = RA1D;
    ra2_e_d      = RA2D;
    wa3_e_d      = WA3D;
    valid_e_d    = ValidD;
    regwrite_e_d = RegWriteD;
    memtoreg_e_d = MemtoRegD;
    if (FlushE) begin
      valid_e_d    = 1'b0;
      regwrite_e_d = 1'b0;
      memtoreg_e_d = 1'b0;
    end

    // M and W never stall or flush: M always takes the old E contents.
    wa3_m_d      = wa3_e_q;
    valid_m_d    = valid_e_q;
    regwrite_m_d = regwrite_e_q;

    wa3_w_d      = wa3_m_q;
    valid_w_d    = valid_m_q;
    regwrite_w_d = regwrite_m_q;

    // The counter saturates at all-ones instead of wrapping.
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra1_e_q      <= '0;
      ra2_e_q      <= '0;
      wa3_e_q      <= '0;
      valid_e_q    <= 1'b0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      wa3_m_q      <= '0;
      valid_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      wa3_w_q      <= '0;
      valid_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ra1_e_q      <= ra1_e_d;
      ra2_e_q      <= ra2_e_d;
      wa3_e_q      <= wa3_e_d;
      valid_e_q    <= valid_e_d;
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      wa3_m_q      <= wa3_m_d;
      valid_m_q    <= valid_m_d;
      regwrite_m_q <= regwrite_m_d;
      wa3_w_q      <= wa3_w_d;
      valid_w_q    <= valid_w_d;
      regwrite_w_q <= regwrite_w_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---------------- compare / output logic ----------------
  logic w_wr_e;
  logic w_wr_m;
  logic w_wr_w;
  logic w_ra1e_ok;
  logic w_ra2e_ok;
  logic w_ra1d_hit;
  logic w_ra2d_hit;

  always_comb begin
    // A stage is a forwarding source only if it holds a real, writing instr.
    w_wr_e     = valid_e_q & regwrite_e_q;
    w_wr_m     = valid_m_q & regwrite_m_q;
    w_wr_w     = valid_w_q & regwrite_w_q;
    w_ra1e_ok  = valid_e_q & (ra1_e_q != c_pc_reg);
    w_ra2e_ok  = valid_e_q & (ra2_e_q != c_pc_reg);
    w_ra1d_hit = (RA1D == wa3_e_q) & (RA1D != c_pc_reg);
    w_ra2d_hit = (RA2D == wa3_e_q) & (RA2D != c_pc_reg);
  end

  assign RA1E        = ra1_e_q;
  assign RA2E        = ra2_e_q;
  assign WA3E        = wa3_e_q;
  assign WA3M        = wa3_m_q;
  assign WA3W        = wa3_w_q;
  assign RegWriteM   = w_wr_m;
  assign RegWriteW   = w_wr_w;
  assign MemtoRegE   = valid_e_q & memtoreg_e_q;
  assign Match_1E_M  = w_ra1e_ok & w_wr_m & (ra1_e_q == wa3_m_q);
  assign Match_1E_W  = w_ra1e_ok & w_wr_w & (ra1_e_q == wa3_w_q);
  assign Match_2E_M  = w_ra2e_ok & w_wr_m & (ra2_e_q == wa3_m_q);
  assign Match_2E_W  = w_ra2e_ok & w_wr_w & (ra2_e_q == wa3_w_q);
  assign Match_12D_E = ValidD & w_wr_e & (w_ra1d_hit | w_ra2d_hit);
  assign BubbleCount = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_match_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_match_pipe
//  Purpose  : Self-checking bench for hazard_match_pipe. A transaction-level
//             model tracks whole instructions per stage and derives every
//             expected output from the forwarding rules. A second instance
//             with a 4-bit counter exercises bubble-count saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_match_pipe;

  localparam int ADDR_W = 4;
  localparam int PC_REG = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [ADDR_W-1:0] RA1D, RA2D, WA3D;
  logic              ValidD, RegWriteD, MemtoRegD, FlushE;

  logic [ADDR_W-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
  logic              RegWriteM, RegWriteW, MemtoRegE;
  logic              Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic [15:0]       BubbleCount;

  logic [ADDR_W-1:0] s_RA1E, s_RA2E, s_WA3E, s_WA3M, s_WA3W;
  logic              s_RegWriteM, s_RegWriteW, s_MemtoRegE;
  logic              s_Match_1E_M, s_Match_1E_W, s_Match_2E_M, s_Match_2E_W, s_Match_12D_E;
  logic [3:0]        s_BubbleCount;

  hazard_match_pipe #(.ADDR_W(ADDR_W), .PC_REG(PC_REG), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .FlushE(FlushE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E), .BubbleCount(BubbleCount)
  );

  hazard_match_pipe #(.ADDR_W(ADDR_W), .PC_REG(PC_REG), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .FlushE(FlushE),
    .RA1E(s_RA1E), .RA2E(s_RA2E), .WA3E(s_WA3E), .WA3M(s_WA3M), .WA3W(s_WA3W),
    .RegWriteM(s_RegWriteM), .RegWriteW(s_RegWriteW), .MemtoRegE(s_MemtoRegE),
    .Match_1E_M(s_Match_1E_M), .Match_1E_W(s_Match_1E_W),
    .Match_2E_M(s_Match_2E_M), .Match_2E_W(s_Match_2E_W),
    .Match_12D_E(s_Match_12D_E), .BubbleCount(s_BubbleCount)
  );

  // One instruction as it travels down the pipe.
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mtr;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
  } instr_t;

  instr_t      me, mm, mw;
  int unsigned nflush;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does the E-stage source 'ra' hit the producer instruction 'x'?
  function automatic logic fwd(input logic [3:0] ra, input instr_t x);
    return me.v && x.v && x.rw && (ra == x.wa3) && (ra != 4'(PC_REG));
  endfunction

  function automatic logic [31:0] sat(input int unsigned n, input int unsigned mx);
    return (n > mx) ? mx : n;
  endfunction

  // Drive one cycle of D inputs, check all outputs mid-cycle, then advance
  // the model at the rising edge. Returns at posedge+1.
  task automatic step(input logic v, input logic rw, input logic mtr,
                      input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                      input logic fl, input logic rn);
    instr_t d;
    d = '{v: v, rw: rw, mtr: mtr, ra1: ra1, ra2: ra2, wa3: wa3};
    ValidD = v; RegWriteD = rw; MemtoRegD = mtr;
    RA1D = ra1; RA2D = ra2; WA3D = wa3; FlushE = fl; reset_n = rn;
    if (!rn) begin
      me = '0; mm = '0; mw = '0; nflush = 0;
    end
    @(negedge clk);
    chk("RegWriteM", 32'(RegWriteM), 32'(mm.v & mm.rw));
    chk("RegWriteW", 32'(RegWriteW), 32'(mw.v & mw.rw));
    chk("MemtoRegE", 32'(MemtoRegE), 32'(me.v & me.mtr));
    chk("Match_1E_M", 32'(Match_1E_M), 32'(fwd(me.ra1, mm)));
    chk("Match_1E_W", 32'(Match_1E_W), 32'(fwd(me.ra1, mw)));
    chk("Match_2E_M", 32'(Match_2E_M), 32'(fwd(me.ra2, mm)));
    chk("Match_2E_W", 32'(Match_2E_W), 32'(fwd(me.ra2, mw)));
    chk("Match_12D_E", 32'(Match_12D_E),
        32'(d.v && me.v && me.rw &&
            ((d.ra1 == me.wa3 && d.ra1 != 4'(PC_REG)) ||
             (d.ra2 == me.wa3 && d.ra2 != 4'(PC_REG)))));
    chk("BubbleCount", 32'(BubbleCount), sat(nflush, 65535));
    chk("BubbleCount4", 32'(s_BubbleCount), sat(nflush, 15));
    if (me.v || !rn) begin
      chk("RA1E", 32'(RA1E), 32'(me.ra1));
      chk("RA2E", 32'(RA2E), 32'(me.ra2));
      chk("WA3E", 32'(WA3E), 32'(me.wa3));
    end
    if (mm.v || !rn) chk("WA3M", 32'(WA3M), 32'(mm.wa3));
    if (mw.v || !rn) chk("WA3W", 32'(WA3W), 32'(mw.wa3));
    @(posedge clk);
    if (!rn) begin
      me = '0; mm = '0; mw = '0; nflush = 0;
    end else begin
      mw = mm;
      mm = me;
      me = fl ? instr_t'('0) : d;
      if (fl) nflush++;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    me = '0; mm = '0; mw = '0; nflush = 0;
    reset_n = 1'b0; ValidD = 0; RegWriteD = 0; MemtoRegD = 0;
    RA1D = 0; RA2D = 0; WA3D = 0; FlushE = 0;

    // Reset held with random D inputs: everything reads zero.
    for (int i = 0; i < 4; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom), 1'b0);
    chk("rst_bubble", 32'(BubbleCount), 32'd0);

    // Back-to-back dependency on r3.
    step(1, 1, 0, 4'd9, 4'd10, 4'd3, 0, 1);
    step(1, 0, 0, 4'd3, 4'd11, 4'd12, 0, 1);
    chk("t2_1E_M", 32'(Match_1E_M), 32'd1);
    step(1, 0, 0, 4'd3, 4'd11, 4'd13, 0, 1);
    chk("t2_1E_W", 32'(Match_1E_W), 32'd1);
    chk("t2_1E_M_off", 32'(Match_1E_M), 32'd0);
    idle(); idle();

    // Load-use on r5 followed by a one-cycle bubble.
    step(1, 1, 1, 4'd1, 4'd2, 4'd5, 0, 1);
    ValidD = 1; RegWriteD = 0; MemtoRegD = 0; RA1D = 4'd7; RA2D = 4'd5; WA3D = 4'd6;
    #1;
    chk("t3_memtoregE", 32'(MemtoRegE), 32'd1);
    chk("t3_12D_E", 32'(Match_12D_E), 32'd1);
    step(1, 0, 0, 4'd7, 4'd5, 4'd6, 1, 1);
    chk("t3_memtoregE_flush", 32'(MemtoRegE), 32'd0);
    chk("t3_12D_E_flush", 32'(Match_12D_E), 32'd0);
    chk("t3_bubbles", 32'(BubbleCount), 32'd1);
    idle(); idle();

    // PC register never matches.
    step(1, 1, 0, 4'd1, 4'd2, 4'd15, 0, 1);
    step(1, 0, 0, 4'd15, 4'd15, 4'd0, 0, 1);
    chk("t4_1E_M", 32'(Match_1E_M), 32'd0);
    chk("t4_2E_M", 32'(Match_2E_M), 32'd0);
    step(1, 0, 0, 4'd15, 4'd15, 4'd0, 0, 1);
    chk("t4_2E_W", 32'(Match_2E_W), 32'd0);
    idle(); idle();

    // Non-writing and invalid producers never match.
    step(1, 0, 0, 4'd1, 4'd2, 4'd7, 0, 1);
    step(1, 0, 0, 4'd7, 4'd7, 4'd0, 0, 1);
    chk("t5_rw0_M", 32'(Match_1E_M), 32'd0);
    step(0, 1, 0, 4'd1, 4'd2, 4'd8, 0, 1);
    step(1, 0, 0, 4'd8, 4'd8, 4'd0, 0, 1);
    chk("t5_v0_M", 32'(Match_2E_M), 32'd0);
    idle(); idle();

    // Saturation of the 4-bit counter, then reset clears it.
    step(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 4'd1, 4'd1, 4'd1, 1, 1);
    chk("t6_sat", 32'(s_BubbleCount), 32'd15);
    chk("t6_cnt16", 32'(BubbleCount), 32'd20);
    step(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
    chk("t6_rst", 32'(s_BubbleCount), 32'd0);

    // Random traffic with small address range to provoke many matches,
    // occasional PC reads, flushes and mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] a1, a2, a3;
      a1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      a2 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      a3 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom), a1, a2, a3, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
